// File: rtl/axis_mux.sv
// Two-to-one AXI4-Stream multiplexer with beat-boundary source switching and a
// fully registered two-entry skid buffer on the master side.
module axis_mux #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  select,
    output logic                  m0_tvalid,
    input  logic                  m0_tready,
    output logic [DATA_WIDTH-1:0] m0_tdata,
    output logic                  sel_active,
    output logic                  busy
);

    logic                  select_q, select_d;
    logic                  ready_q, ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic                  sel_tvalid;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  in_fire;
    logic                  out_fire;

    always_comb begin
        sel_tvalid = select_q ? s1_tvalid : s0_tvalid;
        sel_tdata  = select_q ? s1_tdata : s0_tdata;
        in_fire    = sel_tvalid & ready_q;
        out_fire   = out_valid_q & m0_tready;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (out_fire || !out_valid_q) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = sel_tdata;
                end
            end
        end else if (in_fire) begin
            // ready_q is low whenever the skid is full, so this never overwrites a held beat
            skid_data_d  = sel_tdata;
            skid_valid_d = 1'b1;
        end

        ready_d = ~skid_valid_d;
        // A pending, unaccepted beat on the current source pins the selection.
        select_d = (!sel_tvalid || in_fire) ? select : select_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            select_q     <= 1'b0;
            ready_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            select_q     <= select_d;
            ready_q      <= ready_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid flags.
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign s0_tready  = ready_q & ~select_q;
    assign s1_tready  = ready_q & select_q;
    assign m0_tvalid  = out_valid_q;
    assign m0_tdata   = out_data_q;
    assign sel_active = select_q;
    assign busy       = out_valid_q | skid_valid_q;

endmodule

// File: tb/tb_axis_mux.sv
// Self-checking bench for axis_mux: directed scenarios plus a randomized run
// scored against a queue-based model of accepted-but-not-yet-delivered beats.
module tb_axis_mux;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         s0_tvalid, s1_tvalid, select, m0_tready;
    logic [W-1:0] s0_tdata, s1_tdata;
    logic         s0_tready, s1_tready, m0_tvalid, sel_active, busy;
    logic [W-1:0] m0_tdata;

    int errors = 0;
    int checks = 0;

    axis_mux #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s0_tvalid  (s0_tvalid),
        .s0_tready  (s0_tready),
        .s0_tdata   (s0_tdata),
        .s1_tvalid  (s1_tvalid),
        .s1_tready  (s1_tready),
        .s1_tdata   (s1_tdata),
        .select     (select),
        .m0_tvalid  (m0_tvalid),
        .m0_tready  (m0_tready),
        .m0_tdata   (m0_tdata),
        .sel_active (sel_active),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of accepted beats, at most two in flight.
    logic [W-1:0] mq[$];
    int           m_occ = 0;
    int           n_acc = 0;
    logic         m_ready = 1'b0, m_sel = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
    logic         m_sel_tv, m_in_fire, m_out_fire;

    assign m_sel_tv   = m_sel ? s1_tvalid : s0_tvalid;
    assign m_in_fire  = m_sel_tv & m_ready;
    assign m_out_fire = (m_occ != 0) & m0_tready;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_occ   <= 0;
            m_ready <= 1'b0;
            m_sel   <= 1'b0;
            acc0    <= 1'b0;
            acc1    <= 1'b0;
        end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire) mq.push_back(m_sel ? s1_tdata : s0_tdata);
            m_occ   <= m_occ + (m_in_fire ? 1 : 0) - (m_out_fire ? 1 : 0);
            m_ready <= (m_occ + (m_in_fire ? 1 : 0) - (m_out_fire ? 1 : 0)) < 2;
            m_sel   <= (!m_sel_tv || m_in_fire) ? select : m_sel;
            acc0    <= m_in_fire & ~m_sel;
            acc1    <= m_in_fire & m_sel;
            n_acc   <= n_acc + (m_in_fire ? 1 : 0);
        end
    end

    task automatic test_reset();
        resetn = 1'b0; select = 1'b0; m0_tready = 1'b0;
        s0_tvalid = 1'b1; s0_tdata = 32'h1; s1_tvalid = 1'b0; s1_tdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m0_tvalid: got %b want 0", m0_tvalid); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL reset_s0_tready: got %b want 0", s0_tready); end
        checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL reset_s1_tready: got %b want 0", s1_tready); end
        checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL reset_sel_active: got %b want 0", sel_active); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (s0_tready !== 1'b1) begin errors++; $display("FAIL release_s0_tready: got %b want 1", s0_tready); end
        checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL release_s1_tready: got %b want 0", s1_tready); end
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL release_m0_tvalid: got %b want 0", m0_tvalid); end
        s0_tvalid = 1'b0;
    endtask

    task automatic test_stream();
        m0_tready = 1'b1; select = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s0_tvalid = 1'b1;
            s0_tdata  = 32'(i + 1);
            @(negedge clk);
            checks++;
            if (m0_tvalid !== 1'b1 || m0_tdata !== 32'(i + 1)) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h", i, m0_tvalid, m0_tdata, i + 1);
            end
            checks++; if (s0_tready !== 1'b1) begin errors++; $display("FAIL stream_s0_tready%0d: got %b want 1", i, s0_tready); end
        end
        s0_tvalid = 1'b0;
        @(negedge clk);
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL stream_end_tvalid: got %b want 0", m0_tvalid); end
    endtask

    task automatic test_backpressure();
        int base, idx, nout;
        base = n_acc; idx = 0; nout = 0;
        m0_tready = 1'b0; select = 1'b0; s0_tvalid = 1'b1; s0_tdata = 32'hA0;
        repeat (6) begin
            @(negedge clk);
            if (acc0) begin idx++; s0_tdata = 32'hA0 + 32'(idx); end
        end
        checks++; if (n_acc - base != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", n_acc - base); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL bp_s0_tready: got %b want 0", s0_tready); end
        checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 32'hA0) begin
            errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=a0", m0_tvalid, m0_tdata); end
        m0_tready = 1'b1;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            if (m0_tvalid === 1'b1) begin
                checks++;
                if (m0_tdata !== 32'hA0 + 32'(nout)) begin
                    errors++; $display("FAIL bp_order%0d: got %h want %h", nout, m0_tdata, 32'hA0 + 32'(nout)); end
                nout++;
            end
            @(negedge clk);
            if (c == 0) begin
                checks++; if (s0_tready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", s0_tready); end
            end
            if (acc0) begin
                idx++;
                if (idx >= 6) s0_tvalid = 1'b0;
                else s0_tdata = 32'hA0 + 32'(idx);
            end
        end
        checks++; if (nout != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", nout); end
        @(negedge clk);
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", m0_tvalid); end
    endtask

    task automatic test_switch_stall();
        logic [W-1:0] exp_seq [4] = '{32'h11, 32'h22, 32'h55, 32'h99};
        int idx, nout;
        bit seen;
        idx = 0; nout = 0; seen = 0;
        m0_tready = 1'b0; select = 1'b0; s0_tvalid = 1'b1; s0_tdata = 32'h11;
        repeat (4) begin
            @(negedge clk);
            if (acc0) begin idx++; s0_tdata = (idx == 1) ? 32'h22 : 32'h55; end
        end
        select = 1'b1; s1_tvalid = 1'b1; s1_tdata = 32'h99;
        repeat (3) begin
            @(negedge clk);
            checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL sw_hold_sel: got %b want 0", sel_active); end
            checks++; if (s1_tready !== 1'b0) begin errors++; $display("FAIL sw_hold_s1_tready: got %b want 0", s1_tready); end
        end
        m0_tready = 1'b1;
        for (int c = 0; c < 20 && nout < 4; c++) begin
            if (m0_tvalid === 1'b1) begin
                checks++;
                if (m0_tdata !== exp_seq[nout]) begin
                    errors++; $display("FAIL sw_order%0d: got %h want %h", nout, m0_tdata, exp_seq[nout]); end
                nout++;
            end
            @(negedge clk);
            if (acc0) begin
                seen = 1; s0_tvalid = 1'b0;
                checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL sw_after_sel: got %b want 1", sel_active); end
            end else if (!seen) begin
                checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL sw_before_sel: got %b want 0", sel_active); end
            end
            if (acc1) s1_tvalid = 1'b0;
        end
        checks++; if (nout != 4) begin errors++; $display("FAIL sw_count: got %0d want 4", nout); end
        @(negedge clk);
    endtask

    task automatic test_idle_switch();
        select = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m0_tready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL idle_sel0: got %b want 0", sel_active); end
        select = 1'b1; s1_tvalid = 1'b1; s1_tdata = 32'hBEEF;
        @(negedge clk);
        checks++; if (sel_active !== 1'b1) begin errors++; $display("FAIL idle_sel1: got %b want 1", sel_active); end
        checks++; if (s1_tready !== 1'b1) begin errors++; $display("FAIL idle_s1_tready: got %b want 1", s1_tready); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL idle_s0_tready_a: got %b want 0", s0_tready); end
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL idle_early: got %b want 0", m0_tvalid); end
        @(negedge clk);
        s1_tvalid = 1'b0;
        checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 32'hBEEF) begin
            errors++; $display("FAIL idle_beef: got v=%b d=%h want v=1 d=beef", m0_tvalid, m0_tdata); end
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL idle_s0_tready_b: got %b want 0", s0_tready); end
        @(negedge clk);
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL idle_end: got %b want 0", m0_tvalid); end
    endtask

    task automatic test_random();
        logic [4:0] exp_ctl, got_ctl;
        select = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m0_tready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            exp_ctl = {m_occ != 0, m_ready & ~m_sel, m_ready & m_sel, m_sel, m_occ != 0};
            got_ctl = {m0_tvalid, s0_tready, s1_tready, sel_active, busy};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++; $display("FAIL rand_ctl@%0d: got %b want %b (tvalid,s0r,s1r,sel,busy)", c, got_ctl, exp_ctl); end
            if (m_occ != 0) begin
                checks++;
                if (m0_tdata !== mq[0]) begin
                    errors++; $display("FAIL rand_data@%0d: got %h want %h", c, m0_tdata, mq[0]); end
            end
            if (!s0_tvalid || acc0) begin s0_tvalid = ($urandom_range(0, 3) != 0); s0_tdata = $urandom; end
            if (!s1_tvalid || acc1) begin s1_tvalid = ($urandom_range(0, 3) != 0); s1_tdata = $urandom; end
            if ($urandom_range(0, 7) == 0) select = ~select;
            m0_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m0_tready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (m0_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rand_drain: got v=%b busy=%b want 0 0", m0_tvalid, busy); end
    endtask

    task automatic test_reset_mid();
        int idx;
        idx = 0;
        select = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m0_tready = 1'b1;
        repeat (2) @(negedge clk);
        m0_tready = 1'b0; s1_tvalid = 1'b1; s1_tdata = 32'hC0;
        repeat (3) begin
            @(negedge clk);
            if (acc1) begin idx++; if (idx == 2) s1_tvalid = 1'b0; else s1_tdata = 32'hC1; end
        end
        checks++; if (busy !== 1'b1 || m0_tvalid !== 1'b1 || sel_active !== 1'b1) begin
            errors++; $display("FAIL rm_loaded: got busy=%b v=%b sel=%b want 1 1 1", busy, m0_tvalid, sel_active); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL rm_m0_tvalid: got %b want 0", m0_tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (sel_active !== 1'b0) begin errors++; $display("FAIL rm_sel_active: got %b want 0", sel_active); end
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
            errors++; $display("FAIL rm_treadys: got %b%b want 00", s0_tready, s1_tready); end
        m0_tready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL rm_stale%0d: got %b want 0", c, m0_tvalid); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_switch_stall();
        test_idle_switch();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_mux.md
# axis_mux

Two-to-one AXI4-Stream multiplexer. It merges two 32-bit slave streams onto one master stream, which makes it the collecting counterpart of the stream demultiplexer on the acquisition/generation data paths. A `select` input chooses the source. The choice changes only on beat boundaries, so no beat is dropped, duplicated or reordered. The output is fully registered through a two-entry skid buffer, so there is no combinational path between `m0_tready` and either `s*_tready`.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: width of every tdata bus.

Ports:
- `clk`: input, 1 bit. Single clock for all logic.
- `resetn`: input, 1 bit. Reset is asynchronous and active-low.
- `s0_tvalid`: input, 1 bit. Slave 0 valid.
- `s0_tready`: output, 1 bit. Slave 0 ready.
- `s0_tdata`: input, DATA_WIDTH. Slave 0 data.
- `s1_tvalid`: input, 1 bit. Slave 1 valid.
- `s1_tready`: output, 1 bit. Slave 1 ready.
- `s1_tdata`: input, DATA_WIDTH. Slave 1 data.
- `select`: input, 1 bit. Requested source: 0 = s0, 1 = s1.
- `m0_tvalid`: output, 1 bit. Master valid.
- `m0_tready`: input, 1 bit. Master ready.
- `m0_tdata`: output, DATA_WIDTH. Master data.
- `sel_active`: output, 1 bit. Currently latched source (`select_reg`).
- `busy`: output, 1 bit. `out_valid | skid_valid`.

## Operation

Internal state:
- `select_reg`
- `ready_reg`
- `out_valid`, `out_data` (drive `m0_*` directly)
- `skid_valid`, `skid_data`

Source selection:
- `sel_tvalid` / `sel_tdata` are the slave signals picked by `select_reg`.
- `s0_tready = ready_reg & ~select_reg`.
- `s1_tready = ready_reg & select_reg`.
- The unselected slave always sees tready = 0.
- `in_fire = sel_tvalid & ready_reg`.
- `select_reg <= select` when `sel_tvalid == 0` or `in_fire == 1`. Otherwise it holds.
- A pending unaccepted beat on the selected slave therefore blocks the switch until that beat is taken.

Buffer:
- `out_fire = out_valid & m0_tready`.
- Case A, output free (`out_fire` or `~out_valid`):
  - If `skid_valid`: `out_data <= skid_data`, `out_valid <= 1`, `skid_valid <= 0`.
  - Else: `out_valid <= in_fire`, and `out_data <= sel_tdata` when `in_fire`.
- Case B, output stalled (`out_valid & ~m0_tready`):
  - If `in_fire`: `skid_data <= sel_tdata`, `skid_valid <= 1`.
- `ready_reg <= ~skid_valid_next`, where `skid_valid_next` is the value `skid_valid` takes at this edge.
- `in_fire` never coincides with `skid_valid = 1`, because `ready_reg` is 0 then.

Ordering:
- Output order equals acceptance order across both sources.
- Beats accepted from the old source leave before any beat from the new source.

Reset (asynchronous, any time, including mid-transfer):
- `out_valid`, `skid_valid`, `ready_reg` and `select_reg` clear immediately.
- Buffered beats are discarded.
- Data registers may keep stale values; `m0_tdata` is don't-care while `m0_tvalid = 0`.

## Timing

Reset values:
- `m0_tvalid` = 0
- `s0_tready` = 0
- `s1_tready` = 0
- `sel_active` = 0
- `busy` = 0

After reset release:
- `ready_reg` becomes 1 at the first rising edge.
- The slave selected by `select_reg` then sees tready = 1.

Latency and throughput:
- Latency is 1 cycle: a beat accepted at edge N is on `m0` (`m0_tvalid = 1`) from edge N.
- Throughput is 1 beat/cycle while `m0_tready` stays high.

Backpressure:
- With `m0_tready` low, at most 2 beats are absorbed (output register plus skid).
- `sX_tready` falls at the edge that fills the skid.
- When `m0_tready` returns, the skid moves to the output at the next edge.
- `ready_reg` returns to 1 at that same edge.

Select changes:
- A `select` change with the selected slave idle takes effect at the next edge.
- The new slave can have a beat accepted one cycle later.
- There is no combinational path from `select` to any output.

## Test plan

1. Reset check:
   - Stimulus: hold `resetn` low with `s0_tvalid = 1`.
   - Response: all outputs 0. First edge after release gives `s0_tready = 1`; `s1_tready` stays 0.
2. Streaming on s0:
   - Stimulus: `select = 0`, `m0_tready = 1`, s0 sends 0x1 through 0x8 back-to-back.
   - Response: `m0` shows 0x1 through 0x8 on consecutive cycles, one cycle after each acceptance, with no gaps.
3. Backpressure on s0:
   - Stimulus: s0 streams 0xA0, 0xA1, 0xA2, … with `m0_tready = 0` for 5 cycles, then `m0_tready = 1`.
   - Response: exactly 0xA0 and 0xA1 are accepted, and `s0_tready` drops. After release, `m0` shows 0xA0, 0xA1, 0xA2, … in order with no loss.
4. Switch during a stall:
   - Stimulus: hold `s0_tvalid = 1` with data 0x55 while `ready_reg = 0`, raise `select = 1`, and keep s1 valid with 0x99.
   - Response: `sel_active` stays 0 until 0x55 is accepted. `m0` then shows 0x55 before 0x99.
5. Idle switch:
   - Stimulus: `s0_tvalid = 0`, toggle `select` to 1, s1 sends 0xBEEF.
   - Response: `sel_active = 1` at the next edge, and 0xBEEF appears on `m0` after a 1-cycle latency. `s0_tready` stays 0 throughout.
6. Reset mid-backpressure:
   - Stimulus: two beats buffered (`busy = 1`), then pulse `resetn` low mid-cycle.
   - Response: `m0_tvalid`, `busy`, `sel_active` and both treadys go to 0 without waiting for a clock edge. No stale beat appears after release.
